fetch_stage: RTL

- Instruction Fetch (IF) stage of the MIPS-Lite 5-stage pipeline.
- Owns the program counter and drives the combinational instruction memory address.
- Captures the returned word into the IF/ID pipeline register.
- Handles stalls from the hazard unit, branch/jump redirects from EX, and HALT detection and draining.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID register, handling stalls, EX redirects and HALT draining.
module fetch_stage #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]            HALT_OPCODE = 6'h11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   halt_retired,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [ADDR_WIDTH-1:0]  ifid_pc,
  output logic [ADDR_WIDTH-1:0]  ifid_pc_plus4,
  output logic                   ifid_valid,
  output logic                   halted,
  output logic                   align_err,
  output logic [31:0]            fetch_count
);

  localparam int unsigned CNT_W   = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT_WAIT,
    ST_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_WIDTH-1:0]  ifid_pc_q, ifid_pc_d;
  logic [ADDR_WIDTH-1:0]  ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic                   halted_q, halted_d;
  logic                   align_err_q, align_err_d;
  logic [CNT_W-1:0]       fetch_count_q, fetch_count_d;
  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic                   is_halt;

  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);
  assign is_halt  = (imem_instr[INSTR_WIDTH-1 -: 6] == HALT_OPCODE);

  // Next-state and IF/ID update; every path starts from "hold everything".
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    halted_d        = halted_q;
    align_err_d     = align_err_q;
    fetch_count_d   = fetch_count_q;

    unique case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          pc_d         = redirect_pc;
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end else if (stall) begin
          // hold
        end else if (pc_q[1:0] != 2'b00) begin
          align_err_d  = 1'b1;
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end else begin
          ifid_instr_d    = imem_instr;
          ifid_pc_d       = pc_q;
          ifid_pc_plus4_d = pc_plus4;
          ifid_valid_d    = 1'b1;
          if (fetch_count_q != CNT_MAX) fetch_count_d = fetch_count_q + CNT_W'(1);
          if (is_halt) state_d = ST_HALT_WAIT;
          else         pc_d    = pc_plus4;
        end
      end
      ST_HALT_WAIT: begin
        // A redirect means the HALT was on the wrong path; its fetch stays counted.
        if (redirect_valid) begin
          pc_d         = redirect_pc;
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
          state_d      = ST_RUN;
        end else if (halt_retired) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
          halted_d     = 1'b1;
          state_d      = ST_DONE;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
        end
      end
      ST_DONE: begin
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      pc_q            <= RESET_PC;
      ifid_instr_q    <= '0;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_valid_q    <= 1'b0;
      halted_q        <= 1'b0;
      align_err_q     <= 1'b0;
      fetch_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      halted_q        <= halted_d;
      align_err_q     <= align_err_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign halted        = halted_q;
  assign align_err     = align_err_q;
  assign fetch_count   = fetch_count_q;

endmodule
